speck_decrypt_core: RTL and testbench

//  Iterative SPECK128/128 decryption engine. It is the inverse of the round_encrypt/key_schedule_encrypt chain.
//  It expands the 128-bit key into 32 round keys, stored internally, then applies the 32 inverse rounds in reverse order.
//  It uses the same start/finished handshake as the encrypt blocks and sits beside them in the cipher top level.

---
 rtl/speck_decrypt_core_pkg.sv | 38 +++
 rtl/speck_decrypt_core_round.sv | 16 +
 rtl/speck_decrypt_core.sv | 155 +++++++++++++++
 tb/tb_speck_decrypt_core.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_decrypt_core_pkg.sv
// Shared constants, FSM encoding and rotate helpers for the SPECK128/128 decrypt engine.
// The rotate amounts are fixed, so the helpers are plain bit rewiring with no shifter.
package speck_decrypt_core_pkg;

  localparam int WORD   = 64;
  localparam int ROUNDS = 32;
  localparam int ALPHA  = 8;
  localparam int BETA   = 3;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_EXPAND = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] LAST_ROUND  = CNT_W'(ROUNDS - 1);

  typedef logic [WORD-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_ROUNDS = 2'd2
  } state_t;

  function automatic word_t ror_alpha(input word_t v);
    return {v[ALPHA-1:0], v[WORD-1:ALPHA]};
  endfunction

  function automatic word_t rol_alpha(input word_t v);
    return {v[WORD-1-ALPHA:0], v[WORD-1:WORD-ALPHA]};
  endfunction

  function automatic word_t ror_beta(input word_t v);
    return {v[BETA-1:0], v[WORD-1:BETA]};
  endfunction

  function automatic word_t rol_beta(input word_t v);
    return {v[WORD-1-BETA:0], v[WORD-1:WORD-BETA]};
  endfunction

endpackage

// File: rtl/speck_decrypt_core_round.sv
// Combinational SPECK128 inverse round: undoes one encrypt round given its round key.
module speck_decrypt_core_round
  import speck_decrypt_core_pkg::*;
(
  input  word_t x,
  input  word_t y,
  input  word_t rk,
  output word_t x_next,
  output word_t y_next
);

  // y must be recovered first because x's inverse subtracts the restored y.
  assign y_next = ror_beta(x ^ y);
  assign x_next = rol_alpha((x ^ rk) - y_next);

endmodule

// File: rtl/speck_decrypt_core.sv
// Iterative SPECK128/128 decryption: expands the key into a 32-entry schedule, then
// runs the inverse rounds from rk[31] down to rk[0], one round per clock.
module speck_decrypt_core
  import speck_decrypt_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         signal_start,
  input  logic         key_reuse,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         finished,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshake: signal_start is a request sampled only in IDLE; one accepted start
  // raises busy until the result edge, where finished pulses for one cycle with
  // plaintext valid. The FSM is already in IDLE during that pulse, so a start
  // presented then is accepted. key/ciphertext are only read on the accepting edge.

  state_t           state_q, state_d;
  word_t            x_q, y_q;
  word_t            k_q, l_q;
  logic [CNT_W-1:0] i_q, r_q;
  logic             key_valid_q;

  word_t            rk_mem [ROUNDS];

  logic             start_accept;
  logic             reuse_hit;
  logic             last_expand;
  logic             last_round;
  word_t            l_new, k_new;
  word_t            rk_cur;
  word_t            x_next, y_next;

  assign dbg_state    = state_q;
  assign start_accept = (state_q == ST_IDLE) && signal_start;
  assign reuse_hit    = key_reuse && key_valid_q;
  assign last_expand  = (i_q == LAST_EXPAND);
  assign last_round   = (r_q == '0);
  assign rk_cur       = rk_mem[r_q];

  // k_q mirrors rk[i], so the schedule step never reads the RAM.
  always_comb begin
    l_new = (k_q + ror_alpha(l_q)) ^ {{(WORD-CNT_W){1'b0}}, i_q};
    k_new = rol_beta(k_q) ^ l_new;
  end

  speck_decrypt_core_round u_round (
    .x      (x_q),
    .y      (y_q),
    .rk     (rk_cur),
    .x_next (x_next),
    .y_next (y_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (signal_start) begin
          state_d = reuse_hit ? ST_ROUNDS : ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (last_expand) begin
          state_d = ST_ROUNDS;
        end
      end
      ST_ROUNDS: begin
        if (last_round) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      l_q         <= '0;
      i_q         <= '0;
      r_q         <= '0;
      key_valid_q <= 1'b0;
      plaintext   <= '0;
      finished    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (signal_start) begin
            x_q  <= ciphertext[127:64];
            y_q  <= ciphertext[63:0];
            busy <= 1'b1;
            if (reuse_hit) begin
              r_q <= LAST_ROUND;
            end else begin
              k_q         <= key[127:64];
              l_q         <= key[63:0];
              i_q         <= '0;
              key_valid_q <= 1'b0;
            end
          end
        end
        ST_EXPAND: begin
          l_q <= l_new;
          k_q <= k_new;
          if (last_expand) begin
            key_valid_q <= 1'b1;
            r_q         <= LAST_ROUND;
          end else begin
            i_q <= i_q + CNT_W'(1);
          end
        end
        ST_ROUNDS: begin
          x_q <= x_next;
          y_q <= y_next;
          if (last_round) begin
            plaintext <= {x_next, y_next};
            finished  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_q <= r_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Schedule storage has no reset; key_valid_q alone decides whether it may be reused.
  always_ff @(posedge clk) begin
    if (start_accept && !reuse_hit) begin
      rk_mem[0] <= key[127:64];
    end else if (state_q == ST_EXPAND) begin
      rk_mem[i_q + CNT_W'(1)] <= k_new;
    end
  end

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Bench for speck_decrypt_core: directed handshake scenarios plus random keys, checked
// against a plain SPECK128/128 encrypt model (ciphertext is made from a known plaintext).
module tb_speck_decrypt_core;
  import speck_decrypt_core_pkg::*;

  localparam logic [127:0] KAT_KEY = 128'h0706050403020100_0f0e0d0c0b0a0908;
  localparam logic [127:0] KAT_CT  = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [127:0] KAT_PT  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] RT_KEY  = 128'h753778214125442A472D4B6150645367;
  localparam logic [127:0] RT_PT   = 128'he5b2862a6a7d27f3cf1688b3fbc40c13;

  logic         clk = 1'b0;
  logic         rst;
  logic         signal_start;
  logic         key_reuse;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         finished;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_cmp   = 0;
  int n_err   = 0;
  int fin_cnt = 0;
  logic [127:0] exp_q[$];

  speck_decrypt_core dut (
    .clk          (clk),
    .rst          (rst),
    .signal_start (signal_start),
    .key_reuse    (key_reuse),
    .key          (key),
    .ciphertext   (ciphertext),
    .plaintext    (plaintext),
    .finished     (finished),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (finished === 1'b1) fin_cnt++;
  end

  // reference model
  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [63:0] x, y, a, b;
    x = p[127:64];
    y = p[63:0];
    a = k[127:64];
    b = k[63:0];
    for (int rnd = 0; rnd < 32; rnd++) begin
      x = (ror64(x, 8) + y) ^ a;
      y = rol64(y, 3) ^ x;
      b = (a + ror64(b, 8)) ^ 64'(rnd);
      a = rol64(a, 3) ^ b;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // scoreboard helpers
  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // drivers
  task automatic start_now(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input logic reuse, input logic [127:0] exp_pt);
    key          = k;
    ciphertext   = c;
    key_reuse    = reuse;
    signal_start = 1'b1;
    exp_q.push_back(exp_pt);
    @(posedge clk);
    #1;
    signal_start = 1'b0;
    key          = rand128();
    ciphertext   = rand128();
    checkint({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic start_op(input string tag, input logic [127:0] k, input logic [127:0] c,
                          input logic reuse, input logic [127:0] exp_pt);
    @(negedge clk);
    start_now(tag, k, c, reuse, exp_pt);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < 80 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (finished === 1'b1) seen = 1'b1;
    end
    checkint({tag, "_lat"}, seen ? n : -1, exp_lat);
    check128({tag, "_pt"}, plaintext, pop_exp());
  endtask

  initial begin
    logic [127:0] kb, pb, cb, p2, c2;
    int fc0, nf, blow;

    rst          = 1'b1;
    signal_start = 1'b0;
    key_reuse    = 1'b0;
    key          = '0;
    ciphertext   = '0;
    repeat (3) @(posedge clk);
    #1;
    check128("rst_pt", plaintext, '0);
    checkint("rst_fin", int'(finished), 0);
    checkint("rst_busy", int'(busy), 0);
    checkint("rst_state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    check128("model_kat", model_encrypt(KAT_KEY, KAT_PT), KAT_CT);

    // known answer
    fc0 = fin_cnt;
    start_op("kat", KAT_KEY, KAT_CT, 1'b0, KAT_PT);
    wait_done("kat", 63);
    repeat (3) @(posedge clk);
    checkint("kat_fin_cnt", fin_cnt - fc0, 1);
    check128("kat_hold_pt", plaintext, KAT_PT);

    // round trip
    start_op("rt", RT_KEY, model_encrypt(RT_KEY, RT_PT), 1'b0, RT_PT);
    wait_done("rt", 63);

    // key reuse, then reuse after reset must re-expand
    p2 = rand128();
    c2 = model_encrypt(KAT_KEY, p2);
    start_op("ku0", KAT_KEY, KAT_CT, 1'b0, KAT_PT);
    wait_done("ku0", 63);
    start_op("ku1", rand128(), c2, 1'b1, p2);
    wait_done("ku1", 32);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_op("ku2", KAT_KEY, c2, 1'b1, p2);
    wait_done("ku2", 63);

    // random keys, each used once fresh and once via reuse
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) kb = rand128();
      pb = rand128();
      start_op("rnd", kb, model_encrypt(kb, pb), (j % 2 == 1), pb);
      wait_done("rnd", (j % 2 == 1) ? 32 : 63);
    end

    // start held high; inputs change mid-operation
    kb = rand128();
    pb = rand128();
    cb = model_encrypt(kb, pb);
    @(negedge clk);
    key          = KAT_KEY;
    ciphertext   = KAT_CT;
    key_reuse    = 1'b0;
    signal_start = 1'b1;
    exp_q.push_back(KAT_PT);
    exp_q.push_back(pb);
    nf   = 0;
    blow = 0;
    for (int c = 0; c <= 140; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) begin
        key        = kb;
        ciphertext = cb;
      end
      if (c == 99) signal_start = 1'b0;
      if (c >= 1 && c <= 126 && busy !== 1'b1) blow++;
      if (finished === 1'b1) begin
        nf++;
        checkint("hold_fin_edge", c, (nf == 1) ? 63 : 127);
        check128("hold_pt", plaintext, pop_exp());
      end
    end
    checkint("hold_fin_cnt", nf, 2);
    checkint("hold_busy_gap", blow, 1);
    checkint("hold_idle_busy", int'(busy), 0);

    // reset in the middle of an operation
    fc0 = fin_cnt;
    start_op("abort", KAT_KEY, KAT_CT, 1'b0, KAT_PT);
    void'(pop_exp());
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check128("abort_pt", plaintext, '0);
    checkint("abort_busy", int'(busy), 0);
    checkint("abort_fin", int'(finished), 0);
    checkint("abort_state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    start_op("after_abort", KAT_KEY, KAT_CT, 1'b1, KAT_PT);
    wait_done("after_abort", 63);
    repeat (3) @(posedge clk);
    checkint("abort_fin_cnt", fin_cnt - fc0, 1);

    // back-to-back starts in the finished cycle
    fc0 = fin_cnt;
    kb  = rand128();
    p2  = rand128();
    pb  = rand128();
    start_op("b2b0", KAT_KEY, KAT_CT, 1'b0, KAT_PT);
    wait_done("b2b0", 63);
    start_now("b2b1", rand128(), model_encrypt(KAT_KEY, p2), 1'b1, p2);
    wait_done("b2b1", 32);
    start_now("b2b2", kb, model_encrypt(kb, pb), 1'b0, pb);
    wait_done("b2b2", 63);
    repeat (3) @(posedge clk);
    checkint("b2b_fin_cnt", fin_cnt - fc0, 3);
    checkint("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
